// File: rtl/qr_1t4_rx_deser_align.sv
// Quarter-rate 1:4 RX deserializer with word alignment.
// Finds the 16-bit boundary from a training word, then emits aligned words.
module qr_1t4_rx_deser_align #(
  parameter logic [15:0] SYNC_PATTERN = 16'h0F35,
  parameter int unsigned LOCK_CNT     = 4
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [3:0]  din,
  input  logic        realign,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        locked,
  output logic [1:0]  bit_offset,
  output logic        align_err
);

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_VERIFY,
    S_LOCKED
  } state_t;

  state_t      state_q, state_d;
  logic [18:0] hist_q;
  logic [1:0]  ph_q, ph_d;
  logic [3:0]  mc_q, mc_d;
  logic [3:0]  mc_inc;
  logic [1:0]  off_d;
  logic [15:0] dout_d;
  logic        dv_d;
  logic        aerr_d;
  logic        lock_d;

  logic [15:0] cand [4];
  logic [15:0] sel;
  logic        hit;
  logic [1:0]  hit_k;
  logic        bnd;

  // Four candidate windows, one per possible bit alignment.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      cand[k] = hist_q[k +: 16];
    end
  end

  // Lowest matching alignment wins while searching.
  always_comb begin
    hit   = 1'b0;
    hit_k = 2'd0;
    priority case (1'b1)
      (cand[0] == SYNC_PATTERN): begin hit = 1'b1; hit_k = 2'd0; end
      (cand[1] == SYNC_PATTERN): begin hit = 1'b1; hit_k = 2'd1; end
      (cand[2] == SYNC_PATTERN): begin hit = 1'b1; hit_k = 2'd2; end
      (cand[3] == SYNC_PATTERN): begin hit = 1'b1; hit_k = 2'd3; end
      default: ;
    endcase
  end

  assign sel    = cand[bit_offset];
  assign bnd    = (ph_q == 2'd0);
  assign mc_inc = mc_q + 4'd1;

  // Next-state and output decode; realign overrides every transition.
  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + 2'd1;
    mc_d    = mc_q;
    off_d   = bit_offset;
    dout_d  = data_out;
    dv_d    = 1'b0;
    aerr_d  = 1'b0;
    if (realign) begin
      state_d = S_SEARCH;
      mc_d    = 4'd0;
    end else begin
      unique case (state_q)
        S_SEARCH: begin
          if (hit) begin
            off_d   = hit_k;
            ph_d    = 2'd1;
            mc_d    = 4'd1;
            state_d = S_VERIFY;
          end
        end
        S_VERIFY: begin
          if (bnd) begin
            if (sel == SYNC_PATTERN) begin
              mc_d = mc_inc;
              if (mc_inc == LOCK_N) state_d = S_LOCKED;
            end else begin
              aerr_d  = 1'b1;
              mc_d    = 4'd0;
              state_d = S_SEARCH;
            end
          end
        end
        S_LOCKED: begin
          if (bnd) begin
            dout_d = sel;
            dv_d   = 1'b1;
          end
        end
        default: state_d = S_SEARCH;
      endcase
    end
    lock_d = (state_d == S_LOCKED);
  end

  // State, history shift register and registered outputs.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_SEARCH;
      hist_q     <= '0;
      ph_q       <= '0;
      mc_q       <= '0;
      bit_offset <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      align_err  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= {din, hist_q[18:4]};
      ph_q       <= ph_d;
      mc_q       <= mc_d;
      bit_offset <= off_d;
      data_out   <= dout_d;
      data_valid <= dv_d;
      align_err  <= aerr_d;
      locked     <= lock_d;
    end
  end

endmodule
